// File: rtl/dff_bank_rr_arbiter.sv
// Round-robin arbiter sharing one write port of a small flip-flop register bank
// between NREQ requesters, with a registered read port and a saturating write counter.
module dff_bank_rr_arbiter #(
    parameter int NREQ   = 4,
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 2,
    parameter int CNT_W  = 8,
    localparam int ID_W  = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int DEPTH = 2 ** ADDR_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*ADDR_W-1:0]   wr_addr,
    input  logic [NREQ*WIDTH-1:0]    wr_data,
    output logic [NREQ-1:0]          gnt,
    output logic [ID_W-1:0]          gnt_id,
    input  logic [ADDR_W-1:0]        rd_addr,
    output logic [WIDTH-1:0]         rd_data,
    output logic [CNT_W-1:0]         wr_count
);

    logic [ID_W-1:0]   ptr;
    logic [NREQ-1:0]   eff_req;
    logic              win_vld;
    logic [ID_W-1:0]   win_id;
    logic [ID_W-1:0]   scan_id;
    logic [ADDR_W-1:0] addr_a [NREQ];
    logic [WIDTH-1:0]  data_a [NREQ];
    logic [WIDTH-1:0]  bank   [DEPTH];

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign addr_a[i] = wr_addr[i*ADDR_W +: ADDR_W];
        assign data_a[i] = wr_data[i*WIDTH +: WIDTH];
    end

    // Arbitration: scan from ptr upward; the descending loop lets the nearest hit win.
    // A requester granted last cycle is masked so a held req cannot win twice in a row.
    always_comb begin
        eff_req = req & ~gnt;
        win_vld = 1'b0;
        win_id  = '0;
        scan_id = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            scan_id = ptr + ID_W'(k);
            if (eff_req[scan_id]) begin
                win_vld = 1'b1;
                win_id  = scan_id;
            end
        end
    end

    // Write / grant / read stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int a = 0; a < DEPTH; a++) bank[a] <= '0;
            gnt      <= '0;
            gnt_id   <= '0;
            rd_data  <= '0;
            wr_count <= '0;
            ptr      <= '0;
        end else begin
            rd_data <= bank[rd_addr];
            gnt     <= '0;
            if (win_vld) begin
                bank[addr_a[win_id]] <= data_a[win_id];
                gnt                  <= NREQ'(1) << win_id;
                gnt_id               <= win_id;
                ptr                  <= win_id + ID_W'(1);
                wr_count             <= sat_inc(wr_count);
            end
        end
    end

endmodule

// File: tb/tb_dff_bank_rr_arbiter.sv
// Bench for dff_bank_rr_arbiter: directed scenarios plus random traffic against
// a behavioural model of the bank, pointer and grant rules.
module tb_dff_bank_rr_arbiter;

    localparam int NREQ   = 4;
    localparam int WIDTH  = 8;
    localparam int ADDR_W = 2;
    localparam int CNT_W  = 4;
    localparam int DEPTH  = 4;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NREQ-1:0]        req;
    logic [NREQ*ADDR_W-1:0] wr_addr;
    logic [NREQ*WIDTH-1:0]  wr_data;
    logic [NREQ-1:0]        gnt;
    logic [1:0]             gnt_id;
    logic [ADDR_W-1:0]      rd_addr;
    logic [WIDTH-1:0]       rd_data;
    logic [CNT_W-1:0]       wr_count;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic [WIDTH-1:0] m_bank [DEPTH];
    int               m_ptr;
    logic [NREQ-1:0]  m_gnt;
    int               m_gid;
    logic [WIDTH-1:0] m_rd;
    int               m_cnt;

    dff_bank_rr_arbiter #(
        .NREQ(NREQ), .WIDTH(WIDTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .wr_addr(wr_addr), .wr_data(wr_data),
        .gnt(gnt), .gnt_id(gnt_id), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int a = 0; a < DEPTH; a++) m_bank[a] = '0;
        m_ptr = 0; m_gnt = '0; m_gid = 0; m_rd = '0; m_cnt = 0;
    endtask

    task automatic model_clock();
        int w;
        int idx;
        int ad;
        w = -1;
        for (int k = 0; k < NREQ; k++) begin
            idx = (m_ptr + k) % NREQ;
            if (w < 0 && req[idx] && !m_gnt[idx]) w = idx;
        end
        m_rd = m_bank[rd_addr];
        if (w >= 0) begin
            ad = int'(wr_addr[w*ADDR_W +: ADDR_W]);
            m_bank[ad] = wr_data[w*WIDTH +: WIDTH];
            m_gnt = '0;
            m_gnt[w] = 1'b1;
            m_gid = w;
            m_ptr = (w + 1) % NREQ;
            if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
        end else begin
            m_gnt = '0;
        end
    endtask

    task automatic step();
        model_clock();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        wr_addr = '0; wr_data = 32'hDEAD_BEEF; rd_addr = 2'd0;
        do_reset();
        req = 4'b1111;
        for (int c = 0; c < 5; c++) step();
        #3 rst = 1'b1;
        #1;
        n_checks++;
        if (gnt !== 4'b0000) $display("FAIL reset_gnt: got %b expected %b", gnt, 4'b0000);
        else n_pass++;
        n_checks++;
        if (rd_data !== 8'h00) $display("FAIL reset_rd_data: got %h expected %h", rd_data, 8'h00);
        else n_pass++;
        n_checks++;
        if (wr_count !== 4'h0) $display("FAIL reset_wr_count: got %h expected %h", wr_count, 4'h0);
        else n_pass++;
        n_checks++;
        if (gnt_id !== 2'd0) $display("FAIL reset_gnt_id: got %0d expected 0", gnt_id);
        else n_pass++;
        model_reset();
        #1 rst = 1'b0;
        step();
        n_checks++;
        if (gnt !== 4'b0001) $display("FAIL reset_first_gnt: got %b expected %b", gnt, 4'b0001);
        else n_pass++;
    endtask

    task automatic test_single();
        do_reset();
        req = 4'b0100;
        wr_addr = '0; wr_addr[2*ADDR_W +: ADDR_W] = 2'd2;
        wr_data = '0; wr_data[2*WIDTH +: WIDTH] = 8'hA5;
        rd_addr = 2'd2;
        step();
        n_checks++;
        if (gnt !== 4'b0100 || gnt_id !== 2'd2)
            $display("FAIL single_gnt: got gnt=%b id=%0d expected gnt=0100 id=2", gnt, gnt_id);
        else n_pass++;
        n_checks++;
        if (wr_count !== 4'd1) $display("FAIL single_count: got %0d expected 1", wr_count);
        else n_pass++;
        req = 4'b0000;
        step();
        n_checks++;
        if (rd_data !== 8'hA5) $display("FAIL single_read: got %h expected a5", rd_data);
        else n_pass++;
        n_checks++;
        if (gnt !== 4'b0000) $display("FAIL single_idle_gnt: got %b expected 0000", gnt);
        else n_pass++;
    endtask

    task automatic test_fairness();
        int exp_order [5] = '{0, 1, 2, 3, 0};
        logic [NREQ-1:0] seen;
        do_reset();
        wr_addr = 8'b11_10_01_00;
        wr_data = 32'h4433_2211;
        seen = '0;
        for (int c = 0; c < 5; c++) begin
            req = ~seen;
            step();
            seen = gnt;
            n_checks++;
            if (gnt !== (4'b0001 << exp_order[c]) || int'(gnt_id) != exp_order[c])
                $display("FAIL fairness_%0d: got gnt=%b id=%0d expected id=%0d",
                         c, gnt, gnt_id, exp_order[c]);
            else n_pass++;
        end
    endtask

    task automatic test_masking();
        logic exp_g [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        int   exp_c [4] = '{1, 1, 2, 2};
        do_reset();
        req = 4'b0010;
        for (int c = 0; c < 4; c++) begin
            step();
            n_checks++;
            if (gnt[1] !== exp_g[c] || int'(wr_count) != exp_c[c] || (gnt & 4'b1101) !== 4'b0)
                $display("FAIL masking_%0d: got gnt=%b cnt=%0d expected gnt1=%b cnt=%0d",
                         c, gnt, wr_count, exp_g[c], exp_c[c]);
            else n_pass++;
        end
    endtask

    task automatic test_collision();
        do_reset();
        rd_addr = 2'd1;
        wr_addr = '0; wr_data = '0;
        wr_addr[1*ADDR_W +: ADDR_W] = 2'd1; wr_data[1*WIDTH +: WIDTH] = 8'h77;
        req = 4'b0010;
        step();
        req = 4'b0000;
        step();
        wr_addr[0 +: ADDR_W] = 2'd1;        wr_data[0 +: WIDTH] = 8'h11;
        wr_addr[3*ADDR_W +: ADDR_W] = 2'd1; wr_data[3*WIDTH +: WIDTH] = 8'h33;
        req = 4'b1001;
        step();
        n_checks++;
        if (gnt !== 4'b1000 || rd_data !== 8'h77)
            $display("FAIL collision_first: got gnt=%b rd=%h expected gnt=1000 rd=77", gnt, rd_data);
        else n_pass++;
        req = 4'b0001;
        step();
        n_checks++;
        if (gnt !== 4'b0001 || rd_data !== 8'h33)
            $display("FAIL collision_second: got gnt=%b rd=%h expected gnt=0001 rd=33", gnt, rd_data);
        else n_pass++;
        req = 4'b0000;
        step();
        n_checks++;
        if (rd_data !== 8'h11) $display("FAIL collision_final: got %h expected 11", rd_data);
        else n_pass++;
    endtask

    task automatic test_saturation();
        do_reset();
        wr_addr = '0; wr_data = 32'h0102_0304;
        for (int c = 0; c < 20; c++) begin
            req = 4'b0001 << (c % 2);
            step();
            if (c == 13) begin
                n_checks++;
                if (wr_count !== 4'hE) $display("FAIL sat_14: got %h expected e", wr_count);
                else n_pass++;
            end
        end
        n_checks++;
        if (wr_count !== 4'hF) $display("FAIL sat_20: got %h expected f", wr_count);
        else n_pass++;
    endtask

    task automatic test_random();
        int bad;
        do_reset();
        bad = 0;
        for (int c = 0; c < 300; c++) begin
            req     = 4'($urandom);
            wr_addr = 8'($urandom);
            wr_data = $urandom;
            rd_addr = 2'($urandom);
            if (c % 40 == 0) begin
                req = '0;
                step();
                do_reset();
            end
            step();
            n_checks++;
            if (gnt !== m_gnt || int'(gnt_id) != m_gid || rd_data !== m_rd ||
                int'(wr_count) != m_cnt || !$onehot0(gnt)) begin
                if (bad < 10)
                    $display("FAIL random_%0d: got gnt=%b id=%0d rd=%h cnt=%0d expected gnt=%b id=%0d rd=%h cnt=%0d",
                             c, gnt, gnt_id, rd_data, wr_count, m_gnt, m_gid, m_rd, m_cnt);
                bad++;
            end else n_pass++;
        end
    endtask

    initial begin
        rst = 1'b1; req = '0; wr_addr = '0; wr_data = '0; rd_addr = '0;
        model_reset();
        #12;
        test_reset();
        test_single();
        test_fairness();
        test_masking();
        test_collision();
        test_saturation();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
        $fatal(1);
    end

endmodule

// File: doc/dff_bank_rr_arbiter.md
Name: dff_bank_rr_arbiter

Overview:
Round-robin arbiter that shares the single write port of a small bank of D-flip-flop registers between NREQ requesters. Each requester presents a write address and data with a request. The arbiter grants one requester per clock, performs the write, and returns a one-cycle grant pulse. A registered read port exposes the bank contents to the datapath.

Parameters:
NREQ, 4, number of requesters (power of two, 2..8)
WIDTH, 8, data bits per register
ADDR_W, 2, register address width; bank depth = 2**ADDR_W
CNT_W, 8, width of the total-writes counter

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
req  input  NREQ  per-requester write request, level
wr_addr  input  NREQ*ADDR_W  requester i address at bits [i*ADDR_W +: ADDR_W]
wr_data  input  NREQ*WIDTH  requester i data at bits [i*WIDTH +: WIDTH]
gnt  output  NREQ  registered one-hot grant pulse
gnt_id  output  log2(NREQ), min 1  index of the last granted requester, registered
rd_addr  input  ADDR_W  read address
rd_data  output  WIDTH  registered read data
wr_count  output  CNT_W  saturating count of completed writes

Behaviour:
- Reset, asynchronous, active-high. On assertion, all of the following clear immediately, independent of clk:
  - bank registers = 0, gnt = 0, gnt_id = 0, rd_data = 0, wr_count = 0
  - priority pointer ptr = 0, so requester 0 has highest priority.
- Reset mid-operation: any pending request is not written. Requests still high after reset release are arbitrated from ptr = 0.
- Effective request: eff_req[i] = req[i] & ~gnt[i]. A requester granted in the previous cycle is masked for one cycle. Requesters must drop req in the cycle gnt[i] is seen. A requester that holds req is re-granted at most every other cycle.
- Arbitration (combinational): the winner w is the first i with eff_req[i] = 1, scanning ptr, ptr+1, ... modulo NREQ.
- At the clock edge with a winner:
  - bank[wr_addr_w] <= wr_data_w
  - gnt <= onehot(w), gnt_id <= w
  - ptr <= (w+1) mod NREQ
  - wr_count <= wr_count+1, saturating at all-ones
- At the clock edge with no winner: gnt <= 0. ptr, gnt_id, bank and wr_count hold.
- Latency: the write and gnt are both visible 1 cycle after the request is sampled. Grant throughput is 1 write per cycle whenever any eff_req is set.
- Read: rd_data <= bank[rd_addr] every cycle, 1-cycle latency.
  - If the same address is written on that edge, rd_data returns the OLD value; the new value appears on the next edge.
- Single write port, so two requesters targeting the same address never collide in one cycle. The later grant overwrites the earlier one.
- ptr wraps from NREQ-1 to 0. No requester waits more than NREQ-1 grants while holding req.
- gnt is never multi-hot. gnt = 0 whenever req = 0 in the previous cycle.

Test Plan:
- Reset check: assert rst asynchronously mid-cycle with req = 4'b1111 -> gnt, rd_data and wr_count read 0 immediately. After release, the first grant goes to requester 0 (gnt = 4'b0001).
- Single requester: req = 4'b0100, addr = 2, data = 8'hA5 for 1 cycle -> gnt = 4'b0100 on the next cycle. rd_addr = 2 returns 8'hA5 one cycle later. wr_count = 1.
- Round-robin fairness: all four hold req, each dropping for one cycle after its grant -> grant order 0, 1, 2, 3, 0. gnt_id sequence 0, 1, 2, 3, 0. No double grant.
- Masking: requester 1 holds req continuously, others idle -> gnt[1] pulses 1, 0, 1, 0. wr_count increments every other cycle.
- Collision / read-during-write: requesters 0 and 3 both write addr 1 (8'h11, 8'h33) with ptr = 2 -> requester 3 is granted first, then requester 0. Final bank[1] = 8'h11. rd_data on the write edge shows the prior value.
- Saturation: with CNT_W = 4, perform 20 writes -> wr_count stops at 4'hF.
